mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port synchronous memory (4-bit address, 4-bit data, write-enable S, registered Out).
- Port 0 is the CPU instruction-fetch path and is read-only. Port 1 is the CPU load/store path and can read or write.
- After reset the block clears every memory word (CLEAR phase), then shares the memory between the two ports with round-robin priority.
- Read data is returned one cycle after grant, matching the memory's registered output.

---
 rtl/mem_pkg.sv | 17 +
 rtl/rr_arb2.sv | 26 ++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory arbiter.
package mem_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 4;
  localparam logic [DW_DEF-1:0] CLEAR_VALUE_DEF = '0;

  // Port indices into the request/grant vectors.
  localparam int PORT_FETCH = 0;
  localparam int PORT_LDST  = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: one-hot grant plus the pointer for next time.
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt,
  output logic       o_ptr_next
);

  // Pick a winner; after any grant the other port gets priority.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_gnt      = i_req;
    o_ptr_next = i_ptr;
    if (&i_req) begin
      o_gnt = (i_ptr == 1'(PORT_LDST)) ? 2'b10 : 2'b01;
    end
    if (o_gnt[PORT_FETCH]) begin
      o_ptr_next = 1'(PORT_LDST);
    end else if (o_gnt[PORT_LDST]) begin
      o_ptr_next = 1'(PORT_FETCH);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer in front of a single-port synchronous memory.
// Clears the memory after reset, then shares it round-robin between the
// read-only fetch port (0) and the load/store port (1).
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int            AW             = AW_DEF,
  parameter int            DW             = DW_DEF,
  parameter bit            CLEAR_ON_RESET = 1'b1,
  parameter logic [DW-1:0] CLEAR_VALUE    = DW'(CLEAR_VALUE_DEF)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          ready,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_in,
  output logic          mem_s,
  input  logic [DW-1:0] mem_out
);

  localparam state_t     ST_AFTER_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  // Extra top bit keeps the terminal count unambiguous.
  localparam logic [AW:0] CNT_LAST      = {1'b0, {AW{1'b1}}};

  state_t      r_state;
  state_t      w_state_next;
  logic [AW:0] r_cnt;
  logic        r_ptr;
  logic        w_ptr_next;
  logic [1:0]  w_req;
  logic [1:0]  w_gnt;
  logic        w_run;
  logic        r_p0_rvalid;
  logic        r_p1_rvalid;

  // Requests only count in RUN and never while reset is asserted.
  assign w_run = (r_state == ST_RUN) && !reset;
  assign w_req = w_run ? {p1_req, p0_req} : 2'b00;

  rr_arb2 u_arb (
    .i_req      (w_req),
    .i_ptr      (r_ptr),
    .o_gnt      (w_gnt),
    .o_ptr_next (w_ptr_next)
  );

  assign ready     = (r_state == ST_RUN);
  assign p0_gnt    = w_gnt[PORT_FETCH];
  assign p1_gnt    = w_gnt[PORT_LDST];
  assign p0_rvalid = r_p0_rvalid;
  assign p1_rvalid = r_p1_rvalid;
  assign p0_rdata  = mem_out;
  assign p1_rdata  = mem_out;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_AFTER_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and memory-side mux: clear sweep in CLEAR, granted port in RUN.
  always_comb begin
    w_state_next = r_state;
    mem_address  = '0;
    mem_in       = p1_wdata;
    mem_s        = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_CLEAR: begin
          mem_address = r_cnt[AW-1:0];
          mem_in      = CLEAR_VALUE;
          mem_s       = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_gnt[PORT_LDST]) begin
            mem_address = p1_addr;
            mem_s       = p1_we;
          end else if (w_gnt[PORT_FETCH]) begin
            mem_address = p0_addr;
          end
        end
        default: w_state_next = ST_AFTER_RESET;
      endcase
    end
  end

  // Clear counter and round-robin pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_ptr <= 1'(PORT_FETCH);
    end else begin
      if (r_state == ST_CLEAR) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_ptr <= w_ptr_next;
    end
  end

  // Owner tag: a granted read returns its data on the owner's port next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
    end else begin
      r_p0_rvalid <= w_gnt[PORT_FETCH];
      r_p1_rvalid <= w_gnt[PORT_LDST] & ~p1_we;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: clear sweep, table of RUN-mode cycles,
// reset mid-operation, and an idle instance built without the clear phase.
module tb_mem_arbiter;

  logic       clock;
  logic       reset;

  // Main instance (clears on reset) and its memory model.
  logic       ready;
  logic       p0_req, p0_gnt, p0_rvalid;
  logic [3:0] p0_addr, p0_rdata;
  logic       p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [3:0] p1_addr, p1_wdata, p1_rdata;
  logic [3:0] mem_address, mem_in, mem_out;
  logic       mem_s;
  logic [3:0] mem_model [16];

  // Second instance with no clear phase, memory output tied off.
  logic       nc_ready;
  logic       nc_p0_req, nc_p0_gnt, nc_p0_rvalid;
  logic [3:0] nc_p0_rdata;
  logic       nc_p1_req, nc_p1_gnt, nc_p1_rvalid;
  logic [3:0] nc_p1_rdata;
  logic [3:0] nc_mem_address, nc_mem_in;
  logic       nc_mem_s;
  logic [3:0] nc_mem_out;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.AW(4), .DW(4), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(4'h0)) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_address(mem_address), .mem_in(mem_in), .mem_s(mem_s), .mem_out(mem_out)
  );

  mem_arbiter #(.AW(4), .DW(4), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(4'h0)) dut_nc (
    .clock(clock), .reset(reset), .ready(nc_ready),
    .p0_req(nc_p0_req), .p0_addr(4'h6), .p0_gnt(nc_p0_gnt),
    .p0_rvalid(nc_p0_rvalid), .p0_rdata(nc_p0_rdata),
    .p1_req(nc_p1_req), .p1_we(1'b0), .p1_addr(4'h9), .p1_wdata(4'h0),
    .p1_gnt(nc_p1_gnt), .p1_rvalid(nc_p1_rvalid), .p1_rdata(nc_p1_rdata),
    .mem_address(nc_mem_address), .mem_in(nc_mem_in), .mem_s(nc_mem_s),
    .mem_out(nc_mem_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port memory with registered output (old data on read-during-write).
  always @(posedge clock) begin
    if (mem_s) mem_model[mem_address] <= mem_in;
    mem_out <= mem_model[mem_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       p0_req;
    logic [3:0] p0_addr;
    logic       p1_req;
    logic       p1_we;
    logic [3:0] p1_addr;
    logic [3:0] p1_wdata;
    logic       e_g0;
    logic       e_g1;
    logic       e_s;
    logic [3:0] e_addr;
    logic       e_rv0;
    logic       e_rv1;
    logic [3:0] e_rdata;
  } vec_t;

  vec_t vecs [12];

  initial begin
    // Pointer is at port 0 on entry (the last grant before the table went to port 1).
    //          p0r a   p1r we a     wd     g0 g1 s  addr   rv0 rv1 rdata
    vecs[0]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h5, 4'hA, 1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 4'h0}; // rv: clear-read of addr 0
    vecs[1]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 4'h0}; // write gives no rvalid
    vecs[2]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 4'hC, 1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 4'hA};
    vecs[3]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h2, 4'h7, 1'b0, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 4'h0};
    vecs[4]  = '{1'b1, 4'h2, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 4'h0}; // fetch right after write
    vecs[5]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h4, 4'h9, 1'b0, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0, 4'h7};
    vecs[6]  = '{1'b1, 4'h4, 1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 4'h0}; // contention begins
    vecs[7]  = '{1'b1, 4'h4, 1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 4'h9};
    vecs[8]  = '{1'b1, 4'h4, 1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 4'h4, 1'b0, 1'b1, 4'hC};
    vecs[9]  = '{1'b1, 4'h4, 1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 4'h9};
    vecs[10] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'hC};
    vecs[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};

    reset = 1'b1;
    nc_mem_out = 4'h0;
    nc_p0_req = 1'b0; nc_p1_req = 1'b0;
    p0_req = 1'b0; p0_addr = 4'h0;
    // Load/store read of addr 0 held through the clear phase.
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 4'h0; p1_wdata = 4'h0;

    #1;
    check("rst_mem_s", mem_s, 1'b0);
    check("rst_mem_address", mem_address, 4'h0);
    check("rst_p1_gnt", p1_gnt, 1'b0);
    check("rst_p0_rvalid", p0_rvalid, 1'b0);
    check("rst_p1_rvalid", p1_rvalid, 1'b0);

    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Clear sweep: 16 write cycles, addresses 0..15, held request ignored.
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clock);
      #1;
      check("clr_mem_s", mem_s, 1'b1);
      check("clr_mem_address", mem_address, i[3:0]);
      check("clr_mem_in", mem_in, 4'h0);
      check("clr_ready", ready, 1'b0);
      check("clr_p1_gnt", p1_gnt, 1'b0);
      check("nc_ready", nc_ready, 1'b1);
      check("nc_idle_mem_s", nc_mem_s, 1'b0);
      check("nc_idle_mem_address", nc_mem_address, 4'h0);
      check("nc_idle_p0_gnt", nc_p0_gnt, 1'b0);
      check("nc_idle_p1_gnt", nc_p1_gnt, 1'b0);
    end

    // Cycle 17: ready, held request granted at once.
    @(negedge clock);
    nc_p0_req = 1'b1; nc_p1_req = 1'b1;
    #1;
    check("run_ready", ready, 1'b1);
    check("run_first_p1_gnt", p1_gnt, 1'b1);
    check("run_mem_s", mem_s, 1'b0);
    check("nc_contend_p0_gnt", nc_p0_gnt, 1'b1);
    check("nc_contend_p1_gnt", nc_p1_gnt, 1'b0);

    // Table of RUN-mode cycles.
    for (int v = 0; v < 12; v++) begin
      @(negedge clock);
      nc_p0_req = 1'b0; nc_p1_req = 1'b0;
      p0_req = vecs[v].p0_req; p0_addr = vecs[v].p0_addr;
      p1_req = vecs[v].p1_req; p1_we = vecs[v].p1_we;
      p1_addr = vecs[v].p1_addr; p1_wdata = vecs[v].p1_wdata;
      #1;
      check($sformatf("v%0d_p0_gnt", v), p0_gnt, vecs[v].e_g0);
      check($sformatf("v%0d_p1_gnt", v), p1_gnt, vecs[v].e_g1);
      check($sformatf("v%0d_mem_s", v), mem_s, vecs[v].e_s);
      check($sformatf("v%0d_mem_address", v), mem_address, vecs[v].e_addr);
      check($sformatf("v%0d_p0_rvalid", v), p0_rvalid, vecs[v].e_rv0);
      check($sformatf("v%0d_p1_rvalid", v), p1_rvalid, vecs[v].e_rv1);
      if (vecs[v].e_s) check($sformatf("v%0d_mem_in", v), mem_in, vecs[v].p1_wdata);
      if (vecs[v].e_rv0) check($sformatf("v%0d_p0_rdata", v), p0_rdata, vecs[v].e_rdata);
      if (vecs[v].e_rv1) check($sformatf("v%0d_p1_rdata", v), p1_rdata, vecs[v].e_rdata);
    end

    // Reset lands before the edge that would return a granted fetch.
    @(negedge clock);
    p0_req = 1'b1; p0_addr = 4'h5;
    #1;
    check("mid_p0_gnt", p0_gnt, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_p0_gnt", p0_gnt, 1'b0);
    check("mid_rst_mem_s", mem_s, 1'b0);
    check("mid_rst_mem_address", mem_address, 4'h0);
    check("mid_rst_ready", ready, 1'b0);
    check("mid_rst_p0_rvalid", p0_rvalid, 1'b0);
    p0_req = 1'b0;
    @(negedge clock);
    #1;
    check("mid_rst_p0_rvalid_after_edge", p0_rvalid, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("restart_ready", ready, 1'b0);
    check("restart_mem_s", mem_s, 1'b1);
    check("restart_mem_address", mem_address, 4'h0);
    check("restart_p0_rvalid", p0_rvalid, 1'b0);
    @(negedge clock);
    #1;
    check("restart_mem_address_next", mem_address, 4'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
